// File: rtl/seq_mult8_ctrl_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller.
// SEQ_MULT_ZERO_SKIP_EN enables the zero-nibble step-skip helper.
package seq_mult8_ctrl_pkg;

  localparam int NIB_W  = 4;
  localparam int OPND_W = 8;
  localparam int PROD_W = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PP0  = 3'd1;
  localparam logic [2:0] S_PP1  = 3'd2;
  localparam logic [2:0] S_PP2  = 3'd3;
  localparam logic [2:0] S_PP3  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [3:0] SHIFT_PP0 = 4'd0;
  localparam logic [3:0] SHIFT_PP1 = 4'd4;
  localparam logic [3:0] SHIFT_PP2 = 4'd4;
  localparam logic [3:0] SHIFT_PP3 = 4'd8;

`ifdef SEQ_MULT_ZERO_SKIP_EN
  // Step k uses a-nibble k[0] and b-nibble k[1]; returns the first live step
  // at or after index 'first', or DONE when every remaining step has a zero nibble.
  function automatic logic [2:0] next_live(input logic [2:0] first,
                                           input logic [OPND_W-1:0] a,
                                           input logic [OPND_W-1:0] b);
    logic [2:0]       nxt;
    logic [NIB_W-1:0] na;
    logic [NIB_W-1:0] nb;
    nxt = S_DONE;
    for (int k = 3; k >= 0; k--) begin
      na = (k % 2 == 1) ? a[7:4] : a[3:0];
      nb = (k >= 2)     ? b[7:4] : b[3:0];
      if ((3'(k) >= first) && (na != '0) && (nb != '0))
        nxt = S_PP0 + 3'(k);
    end
    return nxt;
  endfunction
`endif

endpackage

// File: rtl/fourxfourmultiplier.sv
// Combinational 4x4 nibble multiplier (exact variant).
module fourxfourmultiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/seq_mult8_ctrl_nibsel.sv
// Picks the nibble operand pair and accumulate shift for the current PP state.
module seq_mult8_ctrl_nibsel
  import seq_mult8_ctrl_pkg::*;
(
  input  logic [2:0]        state,
  input  logic [OPND_W-1:0] a_q,
  input  logic [OPND_W-1:0] b_q,
  output logic [NIB_W-1:0]  op_a,
  output logic [NIB_W-1:0]  op_b,
  output logic [3:0]        shift
);

  always_comb begin
    op_a  = a_q[3:0];
    op_b  = b_q[3:0];
    shift = SHIFT_PP0;
    case (state)
      S_PP1: begin op_a = a_q[7:4]; op_b = b_q[3:0]; shift = SHIFT_PP1; end
      S_PP2: begin op_a = a_q[3:0]; op_b = b_q[7:4]; shift = SHIFT_PP2; end
      S_PP3: begin op_a = a_q[7:4]; op_b = b_q[7:4]; shift = SHIFT_PP3; end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_mult8_ctrl.sv
// Sequential 8x8 multiplier: one shared 4x4 multiplier stepped over four partials.
// Build option SEQ_MULT_ZERO_SKIP_EN skips partial steps with a zero nibble.
module seq_mult8_ctrl
  import seq_mult8_ctrl_pkg::*;
#(
  parameter bit CLEAR_ON_IDLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] r,
  output logic              busy
);

  logic [2:0]        state_q, state_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] res_q, res_d;
  logic              rdy_en_q;
  logic [OPND_W-1:0] a_q, a_d;
  logic [OPND_W-1:0] b_q, b_d;
  logic [NIB_W-1:0]  op_a, op_b;
  logic [3:0]        shift;
  logic [7:0]        p;
  logic [2:0]        nxt_from_idle, nxt_from_pp;

  seq_mult8_ctrl_nibsel u_nibsel (
    .state (state_q),
    .a_q   (a_q),
    .b_q   (b_q),
    .op_a  (op_a),
    .op_b  (op_b),
    .shift (shift)
  );

  fourxfourmultiplier u_mul (
    .a (op_a),
    .b (op_b),
    .p (p)
  );

`ifdef SEQ_MULT_ZERO_SKIP_EN
  assign nxt_from_idle = next_live(3'd0, a, b);
  assign nxt_from_pp   = next_live(state_q, a_q, b_q);
`else
  // PP states are numbered consecutively, so PP3 + 1 lands on DONE.
  assign nxt_from_idle = S_PP0;
  assign nxt_from_pp   = state_q + 3'd1;
`endif

  assign in_ready  = rdy_en_q && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign r         = out_valid ? acc_q : (CLEAR_ON_IDLE ? '0 : res_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          state_d = nxt_from_idle;
        end
      end
      S_PP0, S_PP1, S_PP2, S_PP3: begin
        acc_d   = acc_q + ({8'h00, p} << shift);
        state_d = nxt_from_pp;
      end
      S_DONE: begin
        if (out_ready) begin
          res_d   = acc_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      res_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Operand latches carry data only and need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

endmodule
